// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR enqueue a byte into a
// small FIFO that a start/data/stop FSM drains onto txd.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_1004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] dataAddress,
    input  logic [31:0] storeData,
    output logic [31:0] statusData,
    output logic        txd,
    output logic        txBusy,
    output logic        overflow
);

    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift, shift_nx;
    logic          full, empty, bit_end;
    logic          push_req, push, pop, drop, ovf_clr;
    logic          txd_nx;
    logic          unused_bits;

    assign push_req    = memWrite && (dataAddress == TX_ADDR);
    assign ovf_clr     = memWrite && (dataAddress == STATUS_ADDR) && storeData[0];
    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign bit_end     = (baud == BAUD_LAST);
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign unused_bits = ^storeData[31:8];

    assign statusData  = {16'h0000, 8'(count), 4'h0, overflow, txBusy, empty, full};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_nx = STOP;
            STOP:    if (bit_end) state_nx = empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        txBusy = (state != IDLE);
        pop    = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            STOP:    pop = bit_end && !empty;
            default: pop = 1'b0;
        endcase
        // txd is driven from the next state so the line register changes on the same edge as the FSM.
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = shift_nx[0];
            default: txd_nx = 1'b1;
        endcase
    end

    always_comb begin
        shift_nx = shift;
        if (pop)
            shift_nx = mem[rd_ptr];
        else if (state == DATA && bit_end)
            shift_nx = {1'b0, shift[7:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud     <= '0;
            bit_idx  <= 3'd0;
            txd      <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            // Pops only happen in IDLE or on a bit boundary, so both restart the baud count.
            if (state == IDLE || bit_end) baud <= '0;
            else                          baud <= baud + 1'b1;
            if (state == START && bit_end)     bit_idx <= 3'd0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
            txd <= txd_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= storeData[7:0];
        shift <= shift_nx;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: vector table, directed corner sequences, random traffic
// against a queue-based frame model, and a line decoder on the captured txd.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] TXA   = 32'h0000_1000;
    localparam logic [31:0] STA   = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        reset;
    logic        memWrite;
    logic [31:0] dataAddress, storeData, statusData;
    logic        txd, txBusy, overflow;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA), .STATUS_ADDR(STA)) dut (
        .clk(clk), .reset(reset), .memWrite(memWrite), .dataAddress(dataAddress),
        .storeData(storeData), .statusData(statusData), .txd(txd), .txBusy(txBusy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    byte unsigned mq[$];
    byte unsigned sent[$];
    bit           m_busy;
    int           m_pos;
    byte unsigned m_cur;
    bit           m_ovf;

    logic         txlog[$];
    byte unsigned dec_bytes[$];
    int           dec_starts[$];
    byte unsigned exp_q[$];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] status;
        logic        txd;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        sent.delete();
        m_busy = 1'b0;
        m_pos  = 0;
        m_cur  = 8'h00;
        m_ovf  = 1'b0;
    endfunction

    // One clock edge: frame position advances, a finished or idle transmitter takes the head byte,
    // then the store is applied to whatever room is left.
    function automatic void model_edge(input bit we, input logic [31:0] addr, input logic [31:0] data);
        bit popped = 1'b0;
        if (m_busy) begin
            m_pos++;
            if (m_pos == FRAME) begin
                if (mq.size() > 0) popped = 1'b1;
                else m_busy = 1'b0;
            end
        end else if (mq.size() > 0) begin
            popped = 1'b1;
            m_busy = 1'b1;
        end
        if (popped) begin
            m_cur = mq.pop_front();
            sent.push_back(m_cur);
            m_pos = 0;
        end
        if (we && addr == STA && data[0]) m_ovf = 1'b0;
        if (we && addr == TXA) begin
            if (mq.size() < DEPTH) mq.push_back(data[7:0]);
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic logic exp_txd();
        if (!m_busy || m_pos >= 9 * CPB) return 1'b1;
        if (m_pos < CPB) return 1'b0;
        return m_cur[(m_pos - CPB) / CPB];
    endfunction

    function automatic logic [31:0] exp_status();
        int n = mq.size();
        return {16'h0000, 8'(n), 4'h0, m_ovf, m_busy, (n == 0), (n == DEPTH)};
    endfunction

    task automatic cycle(input bit we, input logic [31:0] addr, input logic [31:0] data);
        memWrite    = we;
        dataAddress = addr;
        storeData   = data;
        @(posedge clk);
        model_edge(we, addr, data);
        @(negedge clk);
        txlog.push_back(txd);
        check("txd", 32'(txd), 32'(exp_txd()));
        check("txBusy", 32'(txBusy), 32'(m_busy));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("statusData", statusData, exp_status());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0);
    endtask

    // Receiver: sample each bit mid-cell after a start bit; a frame counts only with a valid stop bit.
    function automatic void decode();
        int i = 0;
        dec_bytes.delete();
        dec_starts.delete();
        while (i + FRAME <= txlog.size()) begin
            if (txlog[i] == 1'b0) begin
                byte unsigned b = 8'h00;
                for (int k = 0; k < 8; k++) b[k] = txlog[i + CPB * (k + 1) + CPB / 2];
                if (txlog[i + 9 * CPB + CPB / 2] == 1'b1) begin
                    dec_bytes.push_back(b);
                    dec_starts.push_back(i);
                end
                i += FRAME;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic compare_decoded(input string name);
        decode();
        check({name, "_count"}, 32'(dec_bytes.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dec_bytes.size(); i++)
            check({name, "_byte"}, 32'(dec_bytes[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        memWrite    = 1'b0;
        dataAddress = 32'h0;
        storeData   = 32'h0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
        txlog.delete();
    endtask

    initial begin
        reset = 1'b1;
        memWrite = 1'b0;
        dataAddress = 32'h0;
        storeData = 32'h0;
        #1;
        vecs[0] = '{1'b1, 32'h0000_1008, 32'h0000_00AB, 32'h0000_0002, 1'b1};
        vecs[1] = '{1'b0, TXA,           32'h0000_0012, 32'h0000_0002, 1'b1};
        vecs[2] = '{1'b1, STA,           32'h0000_0001, 32'h0000_0002, 1'b1};
        vecs[3] = '{1'b1, TXA,           32'hFFFF_FF77, 32'h0000_0100, 1'b1};
        vecs[4] = '{1'b0, 32'h0,         32'h0,         32'h0000_0006, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         32'h0,         32'h0000_0006, 1'b0};

        do_reset();
        check("reset_txd", 32'(txd), 32'h1);
        check("reset_busy", 32'(txBusy), 32'h0);
        check("reset_status", statusData, 32'h0000_0002);

        // Address filter, ignored upper data bits, pop one edge after push
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].data);
            check("vec_status", statusData, vecs[i].status);
            check("vec_txd", 32'(txd), 32'(vecs[i].txd));
        end
        idle(FRAME);
        exp_q = '{8'h77};
        compare_decoded("vec_frame");

        // Single 0x55 frame, cycle-exact
        txlog.delete();
        cycle(1'b1, TXA, 32'h0000_0055);
        for (int c = 1; c <= 41; c++) begin
            logic e;
            cycle(1'b0, 32'h0, 32'h0);
            if (c <= 4)       e = 1'b0;
            else if (c <= 36) e = (8'h55 >> ((c - 5) / 4)) & 8'h01;
            else              e = 1'b1;
            if (c <= 40) check("single_bit", 32'(txd), 32'(e));
        end
        check("single_idle_busy", 32'(txBusy), 32'h0);
        check("single_idle_status", statusData, 32'h0000_0002);

        // Back-to-back frames with no gap
        txlog.delete();
        cycle(1'b1, TXA, 32'h0000_00A5);
        cycle(1'b1, TXA, 32'h0000_003C);
        idle(2 * FRAME + 4);
        exp_q = '{8'hA5, 8'h3C};
        compare_decoded("b2b");
        check("b2b_gap", dec_starts.size() >= 2 ? 32'(dec_starts[1] - dec_starts[0]) : 32'hFFFF_FFFF, 32'(FRAME));

        // Overflow, clear, then push on the edge where STOP pops a full FIFO
        txlog.delete();
        for (int b = 0; b < 10; b++) cycle(1'b1, TXA, 32'(b));
        check("ovf_status", statusData, 32'h0000_080D);
        check("ovf_flag", 32'(overflow), 32'h1);
        cycle(1'b1, STA, 32'h0000_0001);
        check("ovf_clear", 32'(overflow), 32'h0);
        idle(30);
        check("full_before_pop", statusData, 32'h0000_0805);
        cycle(1'b1, TXA, 32'h0000_00EE);
        check("push_pop_full_status", statusData, 32'h0000_0805);
        check("push_pop_full_ovf", 32'(overflow), 32'h0);
        idle(9 * FRAME + 4);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEE};
        compare_decoded("ovf_seq");
        check("ovf_drained", statusData, 32'h0000_0002);

        // Asynchronous reset in the middle of data bit 3
        txlog.delete();
        cycle(1'b1, TXA, 32'h0000_0011);
        cycle(1'b1, TXA, 32'h0000_0022);
        cycle(1'b1, TXA, 32'h0000_0033);
        cycle(1'b1, TXA, 32'h0000_0044);
        idle(16);
        check("pre_reset_status", statusData, 32'h0000_0304);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_txd", 32'(txd), 32'h1);
        check("mid_reset_busy", 32'(txBusy), 32'h0);
        check("mid_reset_status", statusData, 32'h0000_0002);
        check("mid_reset_ovf", 32'(overflow), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        txlog.delete();
        cycle(1'b1, TXA, 32'h0000_0096);
        idle(FRAME + 2);
        exp_q = '{8'h96};
        compare_decoded("after_reset");

        // Random traffic against the model
        txlog.delete();
        sent.delete();
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 35)      cycle(1'b1, TXA, $urandom);
            else if (r < 40) cycle(1'b1, STA, $urandom);
            else if (r < 50) cycle(1'b1, 32'h0000_2000 + 32'($urandom_range(0, 255)) * 4, $urandom);
            else if (r < 60) cycle(1'b0, TXA, $urandom);
            else             cycle(1'b0, 32'h0, 32'h0);
        end
        idle((DEPTH + 1) * FRAME + 4);
        exp_q = sent;
        compare_decoded("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
